// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and transmitter-side signals of the UART
// transmit arbiter. The arbiter connects through the "slave" modport; the
// requesters plus the shared UART transmitter drive the "master" modport.
interface uart_tx_arbiter_if;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  REQ_PAR_EN;
  logic [3:0]  REQ_PAR_TYP;
  logic [3:0]  GNT;
  logic        TX_BUSY;
  logic [7:0]  P_DATA;
  logic        Data_Valid;
  logic        PAR_EN;
  logic        PAR_TYP;

  modport master (
    output REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, TX_BUSY,
    input  GNT, P_DATA, Data_Valid, PAR_EN, PAR_TYP
  );

  modport slave (
    input  REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, TX_BUSY,
    output GNT, P_DATA, Data_Valid, PAR_EN, PAR_TYP
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between four
// requesters. A winner's byte and parity settings are latched, launched with
// a one-cycle Data_Valid/GNT strobe, and held until the inter-frame gap ends.
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the busy-rise
// timeout (TO_ERR pulse and recovery to GAP); otherwise WAIT_BUSY waits
// indefinitely and TO_ERR is constant 0.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_arbiter_if.slave     bus,
  output logic [1:0]           OWNER,
  output logic                 ACTIVE,
  output logic                 TO_ERR
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    SEND      = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Last gap-counter value before returning to IDLE (unused when GAP_CYCLES=0).
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      r_state;
  logic [7:0]  r_p_data;
  logic        r_data_valid;
  logic        r_par_en;
  logic        r_par_typ;
  logic [3:0]  r_gnt;
  logic [1:0]  r_owner;
  logic        r_active;
  logic [15:0] r_gap_cnt;

  logic        w_pick_valid;
  logic [1:0]  w_pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  // The count starts on entry to WAIT_BUSY, one cycle after Data_Valid, so
  // the error fires BUSY_TIMEOUT cycles after Data_Valid. Values below 2 clamp.
  localparam logic [15:0] TO_LAST = (BUSY_TIMEOUT >= 2) ? 16'(BUSY_TIMEOUT - 2) : 16'd0;
  logic [15:0] r_to_cnt;
  logic        r_to_err;
`endif

  // Round-robin search starting after the last owner; i=4 wraps to the owner itself.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_pick_valid && bus.REQ[r_owner + 2'(i)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = r_owner + 2'(i);
      end else begin
        w_pick_valid = w_pick_valid;
      end
    end
  end

  // Arbitration FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_p_data     <= 8'h00;
      r_data_valid <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_gnt        <= 4'b0000;
      r_owner      <= 2'd3;
      r_active     <= 1'b0;
      r_gap_cnt    <= 16'd0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt     <= 16'd0;
      r_to_err     <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_gnt        <= 4'b0000;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_err     <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_p_data     <= bus.REQ_DATA[{w_pick_idx, 3'b000} +: 8];
            r_par_en     <= bus.REQ_PAR_EN[w_pick_idx];
            r_par_typ    <= bus.REQ_PAR_TYP[w_pick_idx];
            r_owner      <= w_pick_idx;
            r_data_valid <= 1'b1;
            r_gnt        <= 4'b0001 << w_pick_idx;
            r_active     <= 1'b1;
            r_state      <= LAUNCH;
          end else begin
            r_state      <= IDLE;
          end
        end
        LAUNCH: begin
          r_state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          r_to_cnt <= 16'd0;
`endif
        end
        WAIT_BUSY: begin
          if (bus.TX_BUSY) begin
            r_state <= SEND;
          end else begin
`ifdef UART_ARB_TIMEOUT_EN
            if (r_to_cnt == TO_LAST) begin
              r_to_err <= 1'b1;
              if (GAP_CYCLES == 0) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
              end else begin
                r_state   <= GAP;
                r_gap_cnt <= 16'd0;
              end
            end else begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
`else
            r_state <= WAIT_BUSY;
`endif
          end
        end
        SEND: begin
          if (!bus.TX_BUSY) begin
            if (GAP_CYCLES == 0) begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= 16'd0;
            end
          end else begin
            r_state <= SEND;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.Data_Valid = r_data_valid;
  assign bus.PAR_EN     = r_par_en;
  assign bus.PAR_TYP    = r_par_typ;
  assign bus.GNT        = r_gnt;
  assign OWNER          = r_owner;
  assign ACTIVE         = r_active;
`ifdef UART_ARB_TIMEOUT_EN
  assign TO_ERR         = r_to_err;
`else
  assign TO_ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of grant vectors applied in a
// loop, each followed by a frame with busy handshake and gap measurement,
// plus hand sequences for mid-frame reset and the busy-wait / timeout path.
module tb_uart_tx_arbiter;
  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] OWNER;
  logic       ACTIVE;
  logic       TO_ERR;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.GAP_CYCLES(2), .BUSY_TIMEOUT(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus),
    .OWNER  (OWNER),
    .ACTIVE (ACTIVE),
    .TO_ERR (TO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  pen;
    logic [3:0]  ptyp;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  pdata;
    logic        epen;
    logic        eptyp;
  } vec_t;

  vec_t vt[10];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.REQ         = v.req;
    bus.REQ_DATA    = v.data;
    bus.REQ_PAR_EN  = v.pen;
    bus.REQ_PAR_TYP = v.ptyp;
  endtask

  // Checks taken in the LAUNCH cycle, one edge after REQ was sampled in IDLE.
  task automatic check_launch(input vec_t v, input string tag);
    chk({tag, "_dv"},     32'(bus.Data_Valid), 32'd1);
    chk({tag, "_gnt"},    32'(bus.GNT),        32'(v.gnt));
    chk({tag, "_owner"},  32'(OWNER),          32'(v.owner));
    chk({tag, "_pdata"},  32'(bus.P_DATA),     32'(v.pdata));
    chk({tag, "_paren"},  32'(bus.PAR_EN),     32'(v.epen));
    chk({tag, "_partyp"}, 32'(bus.PAR_TYP),    32'(v.eptyp));
    chk({tag, "_active"}, 32'(ACTIVE),         32'd1);
  endtask

  // Busy handshake with scrambled requester inputs, then gap length measurement.
  task automatic frame_tail(input vec_t v, input string tag);
    int   g;
    logic dv_seen;
    g       = 0;
    dv_seen = 1'b0;
    bus.REQ_DATA    = ~v.data;
    bus.REQ_PAR_EN  = ~v.pen;
    bus.REQ_PAR_TYP = ~v.ptyp;
    bus.TX_BUSY     = 1'b1;
    tick;
    chk({tag, "_dv_low"},  32'(bus.Data_Valid), 32'd0);
    chk({tag, "_gnt_low"}, 32'(bus.GNT),        32'd0);
    tick;
    chk({tag, "_pdata_hold"}, 32'(bus.P_DATA), 32'(v.pdata));
    chk({tag, "_par_hold"},   32'({bus.PAR_EN, bus.PAR_TYP}), 32'({v.epen, v.eptyp}));
    tick;
    bus.TX_BUSY = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (bus.Data_Valid) dv_seen = 1'b1;
      if (!ACTIVE) break;
      g++;
    end
    chk({tag, "_gap_len"}, 32'(g), 32'd2);
    chk({tag, "_no_dv"},   32'(dv_seen), 32'd0);
`ifndef UART_ARB_TIMEOUT_EN
    chk({tag, "_to_err"},  32'(TO_ERR), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic dv_seen;
    vt[0] = '{4'hF, 32'h4433_2211, 4'b0101, 4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1, 1'b1};
    vt[1] = '{4'hF, 32'h4433_2211, 4'b0101, 4'b0011, 4'b0010, 2'd1, 8'h22, 1'b0, 1'b1};
    vt[2] = '{4'hF, 32'h4433_2211, 4'b0101, 4'b0011, 4'b0100, 2'd2, 8'h33, 1'b1, 1'b0};
    vt[3] = '{4'hF, 32'h4433_2211, 4'b0101, 4'b0011, 4'b1000, 2'd3, 8'h44, 1'b0, 1'b0};
    vt[4] = '{4'hF, 32'h4433_2211, 4'b0101, 4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1, 1'b1};
    vt[5] = '{4'h4, 32'h00A5_0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b0};
    vt[6] = '{4'h4, 32'h00A5_0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b0};
    vt[7] = '{4'h9, 32'h5A00_003C, 4'b1001, 4'b0001, 4'b1000, 2'd3, 8'h5A, 1'b1, 1'b0};
    vt[8] = '{4'h9, 32'h5A00_003C, 4'b1001, 4'b0001, 4'b0001, 2'd0, 8'h3C, 1'b1, 1'b1};
    vt[9] = '{4'h2, 32'h0000_7E00, 4'b0000, 4'b0010, 4'b0010, 2'd1, 8'h7E, 1'b0, 1'b1};

    // Reset for two edges with every requester asserting.
    RST         = 1'b1;
    bus.TX_BUSY = 1'b0;
    apply(vt[0]);
    tick;
    tick;
    chk("rst_owner",  32'(OWNER),          32'd3);
    chk("rst_active", 32'(ACTIVE),         32'd0);
    chk("rst_dv",     32'(bus.Data_Valid), 32'd0);
    chk("rst_gnt",    32'(bus.GNT),        32'd0);
    chk("rst_pdata",  32'(bus.P_DATA),     32'd0);
    chk("rst_par",    32'({bus.PAR_EN, bus.PAR_TYP}), 32'd0);
    chk("rst_to_err", 32'(TO_ERR),         32'd0);
    RST = 1'b0;

    // Table-driven grants: round-robin, single requester, wrap order.
    for (int i = 0; i < 10; i++) begin
      apply(vt[i]);
      tick;
      check_launch(vt[i], $sformatf("v%0d", i));
      frame_tail(vt[i], $sformatf("v%0d", i));
    end

    // Mid-frame reset: owner 1 -> enter SEND, then reset.
    apply('{4'h2, 32'h0000_C300, 4'b0010, 4'b0000, 4'b0010, 2'd1, 8'hC3, 1'b1, 1'b0});
    tick;
    chk("mf_launch_gnt", 32'(bus.GNT), 32'd2);
    bus.TX_BUSY = 1'b1;
    tick;
    tick;
    RST = 1'b1;
    apply(vt[0]);
    tick;
    chk("mf_active", 32'(ACTIVE),         32'd0);
    chk("mf_owner",  32'(OWNER),          32'd3);
    chk("mf_dv",     32'(bus.Data_Valid), 32'd0);
    chk("mf_pdata",  32'(bus.P_DATA),     32'd0);
    tick;
    chk("mf_dv_hold", 32'(bus.Data_Valid), 32'd0);
    RST         = 1'b0;
    bus.TX_BUSY = 1'b0;
    tick;
    check_launch(vt[0], "mf_first");
    frame_tail(vt[0], "mf_first");

`ifdef UART_ARB_TIMEOUT_EN
    // Busy never rises: TO_ERR 4 cycles after Data_Valid, then gap, then regrant.
    apply(vt[9]);
    tick;
    check_launch(vt[9], "to");
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      n++;
      if (TO_ERR) break;
    end
    chk("to_delay", 32'(n), 32'd4);
    n       = 0;
    dv_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      n++;
      if (TO_ERR) dv_seen = 1'b1;
      if (bus.Data_Valid) break;
    end
    chk("to_pulse_once", 32'(dv_seen), 32'd0);
    chk("to_regrant_delay", 32'(n), 32'd3);
    chk("to_regrant_gnt", 32'(bus.GNT), 32'd2);
`else
    // Busy never rises: WAIT_BUSY must hold with no error and no relaunch.
    apply(vt[9]);
    tick;
    check_launch(vt[9], "wb");
    dv_seen = 1'b0;
    n       = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (bus.Data_Valid) dv_seen = 1'b1;
      if (TO_ERR) n++;
    end
    chk("wb_active", 32'(ACTIVE),  32'd1);
    chk("wb_no_dv",  32'(dv_seen), 32'd0);
    chk("wb_no_err", 32'(n),       32'd0);
    bus.TX_BUSY = 1'b1;
    tick;
    tick;
    bus.TX_BUSY = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      n++;
      if (bus.Data_Valid) break;
    end
    chk("wb_regrant_delay", 32'(n), 32'd4);
    chk("wb_regrant_gnt",   32'(bus.GNT), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
